// File: rtl/tick_scheduler_pkg.sv
// ============================================================================
// Module      : tick_scheduler_pkg
// Description : Shared state encoding and default sizing for tick_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_scheduler_pkg;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN
    } state_t;

    localparam int          c_WIDTH     = 17;
    localparam int          c_N_REQ     = 4;
    localparam logic [16:0] c_DIV_RESET = 17'h1FFFF;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick starting after the last owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] next_ptr
);

    int   w_idx;
    logic w_found;

    // Pointer is left unchanged when nobody requests.
    always_comb begin
        grant    = '0;
        next_ptr = last_ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(last_ptr) + k) % N_REQ;
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                grant[w_idx]  = 1'b1;
                next_ptr      = PTR_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
// Module      : tick_scheduler
// Description : Programmable tick divider with round-robin period ownership.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int               WIDTH     = c_WIDTH,
    parameter int               N_REQ     = c_N_REQ,
    parameter logic [WIDTH-1:0] DIV_RESET = WIDTH'(c_DIV_RESET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_divisor,
    output logic             cfg_ready,
    input  logic [N_REQ-1:0] req,
    output logic             tick,
    output logic [N_REQ-1:0] grant,
    output logic             running
);

    localparam int c_PTR_W = ptr_width(N_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_counter;
    logic [WIDTH-1:0]   r_div_active;
    logic [WIDTH-1:0]   r_div_pend;
    logic               r_pend_valid;
    logic [c_PTR_W-1:0] r_last_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   w_arb_grant;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic               w_xfer;

    assign cfg_ready = !r_pend_valid;
    assign w_xfer    = cfg_valid && !r_pend_valid;
    assign tick      = (r_state == ST_RUN) && (r_counter == r_div_active);
    assign running   = (r_state == ST_RUN);
    assign grant     = r_grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .req      (req),
        .last_ptr (r_last_ptr),
        .grant    (w_arb_grant),
        .next_ptr (w_next_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stop dominates start; start is meaningless once running.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE) begin
            if (start && !stop) begin
                w_state_nxt = ST_RUN;
            end
        end else if (stop) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_counter    <= '0;
            r_div_active <= DIV_RESET;
            r_div_pend   <= '0;
            r_pend_valid <= 1'b0;
            r_last_ptr   <= c_PTR_W'(N_REQ - 1);
            r_grant      <= '0;
        end else if (r_state == ST_IDLE) begin
            r_counter <= '0;
            if (w_xfer) begin
                r_div_active <= cfg_divisor;
            end
        end else if (stop || tick) begin
            // Period boundary: a fresh transfer beats the parked value.
            r_counter    <= '0;
            r_pend_valid <= 1'b0;
            if (w_xfer) begin
                r_div_active <= cfg_divisor;
            end else if (r_pend_valid) begin
                r_div_active <= r_div_pend;
            end
            if (stop) begin
                r_grant <= '0;
            end else begin
                r_grant    <= w_arb_grant;
                r_last_ptr <= w_next_ptr;
            end
        end else begin
            r_counter <= r_counter + WIDTH'(1);
            if (w_xfer) begin
                r_div_pend   <= cfg_divisor;
                r_pend_valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Scoreboard bench for tick_scheduler against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_scheduler;

    localparam int c_W = 17;
    localparam int c_N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [c_W-1:0] cfg_divisor = '0;
    logic           cfg_ready;
    logic [c_N-1:0] req = '0;
    logic           tick;
    logic [c_N-1:0] grant;
    logic           running;

    typedef struct {
        logic           tick;
        logic [c_N-1:0] grant;
        logic           running;
        logic           cfg_ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model: period phase, active/parked divisor, last owner.
    bit             m_run;
    int             m_phase;
    int             m_div;
    int             m_pend;
    bit             m_pend_ok;
    int             m_last;
    logic [c_N-1:0] m_grant;

    tick_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_divisor (cfg_divisor),
        .cfg_ready   (cfg_ready),
        .req         (req),
        .tick        (tick),
        .grant       (grant),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_div = 'h1FFFF; m_pend = 0;
        m_pend_ok = 0; m_last = c_N - 1; m_grant = '0;
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.tick      = m_run && (m_phase == m_div);
        e.grant     = m_grant;
        e.running   = m_run;
        e.cfg_ready = !m_pend_ok;
        return e;
    endfunction

    task automatic model_step(input bit s, input bit p, input bit cv, input int cd,
                              input logic [c_N-1:0] rq);
        bit end_of_period;
        bit accept;
        end_of_period = m_run && (m_phase == m_div);
        accept        = cv && !m_pend_ok;
        if (!m_run) begin
            if (accept) m_div = cd;
            m_run   = s && !p;
            m_phase = 0;
        end else if (p || end_of_period) begin
            if (accept) m_div = cd;
            else if (m_pend_ok) m_div = m_pend;
            m_pend_ok = 0;
            m_phase   = 0;
            if (p) begin
                m_run   = 0;
                m_grant = '0;
            end else begin
                m_grant = '0;
                for (int k = 1; k <= c_N; k++) begin
                    if (rq[(m_last + k) % c_N]) begin
                        m_last  = (m_last + k) % c_N;
                        m_grant = c_N'(1) << m_last;
                        break;
                    end
                end
            end
        end else begin
            m_phase++;
            if (accept) begin
                m_pend    = cd;
                m_pend_ok = 1;
            end
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic do_cycle(input bit s, input bit p, input bit cv, input int cd,
                            input logic [c_N-1:0] rq);
        start = s; stop = p; cfg_valid = cv; cfg_divisor = c_W'(cd); req = rq;
        model_step(s, p, cv, cd, rq);
        @(posedge clk);
        #1;
        exp_q.push_back(model_expect());
    endtask

    task automatic idle_cycles(input int n, input logic [c_N-1:0] rq);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, rq);
    endtask

    task automatic reset_pulse();
        exp_t e;
        #5;
        reset = 1'b0;
        model_reset();
        #1;
        e = model_expect();
        check("async_reset_tick", int'(tick), int'(e.tick));
        check("async_reset_grant", int'(grant), int'(e.grant));
        check("async_reset_running", int'(running), int'(e.running));
        check("async_reset_cfg_ready", int'(cfg_ready), int'(e.cfg_ready));
        @(posedge clk);
        #1;
        exp_q.push_back(model_expect());
        #1;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick", int'(tick), int'(e.tick));
                check("grant", int'(grant), int'(e.grant));
                check("running", int'(running), int'(e.running));
                check("cfg_ready", int'(cfg_ready), int'(e.cfg_ready));
            end
        end
    end

    initial begin : driver
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_expect());
        #1;
        reset = 1'b1;

        // Divisor 3 configured while idle: ticks 4, 8, 12 cycles after start.
        do_cycle(0, 0, 1, 3, 4'b0000);
        do_cycle(1, 0, 0, 0, 4'b0000);
        idle_cycles(14, 4'b0000);
        do_cycle(0, 1, 0, 0, 4'b0000);

        // Divisor 0 ticks every running cycle; stop clears it next cycle.
        do_cycle(0, 0, 1, 0, 4'b0000);
        do_cycle(1, 0, 0, 0, 4'b0000);
        idle_cycles(5, 4'b0000);
        do_cycle(0, 1, 0, 0, 4'b0000);
        idle_cycles(2, 4'b0000);

        // Period 6 with a mid-period change to 2 parked until terminal count.
        do_cycle(0, 0, 1, 5, 4'b0000);
        do_cycle(1, 0, 0, 0, 4'b0000);
        idle_cycles(8, 4'b0000);
        do_cycle(0, 0, 1, 2, 4'b0000);
        idle_cycles(12, 4'b0000);
        do_cycle(0, 1, 0, 0, 4'b0000);

        // Round-robin over 1011, then no requesters.
        do_cycle(0, 0, 1, 1, 4'b1011);
        do_cycle(1, 0, 0, 0, 4'b1011);
        idle_cycles(9, 4'b1011);
        idle_cycles(4, 4'b0000);
        do_cycle(0, 1, 0, 0, 4'b0000);

        // Simultaneous start and stop keeps the block idle.
        do_cycle(1, 1, 0, 0, 4'b0000);
        idle_cycles(2, 4'b0000);

        // Asynchronous reset while requester 2 owns the period.
        do_cycle(0, 0, 1, 1, 4'b0100);
        do_cycle(1, 0, 0, 0, 4'b0100);
        idle_cycles(4, 4'b0100);
        reset_pulse();
        idle_cycles(3, 4'b0100);

        // Randomised traffic with small divisors.
        for (int i = 0; i < 2000; i++) begin
            do_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                     $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)),
                     c_N'($urandom_range(0, 15)));
            if ($urandom_range(0, 999) == 0) reset_pulse();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter WIDTH, default 17: width of divisor register and period counter.
REQ-002 Parameter N_REQ, default 4: number of requesters sharing the divided tick.
REQ-003 Parameter DIV_RESET, default 17'h1FFFF: active divisor after reset.
REQ-004 One clock, `clk`; reset is asynchronous and active-low (port `reset`).
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  level; begin counting when in IDLE.
REQ-008 stop  input  1  level; halt counting, return to IDLE.
REQ-009 cfg_valid  input  1  new divisor offered.
REQ-010 cfg_divisor  input  WIDTH  offered divisor; period = cfg_divisor+1 cycles.
REQ-011 cfg_ready  output  1  divisor can be accepted this cycle.
REQ-012 req  input  N_REQ  per-requester tick request, level.
REQ-013 tick  output  1  one-cycle pulse at terminal count.
REQ-014 grant  output  N_REQ  registered one-hot owner of current period, or all-zero.
REQ-015 running  output  1  high in RUN state.

Function
REQ-016 FSM SHALL have two states, IDLE and RUN.
REQ-017 IDLE->RUN when start=1 and stop=0; stop wins when both are high; start in RUN SHALL be ignored.
REQ-018 RUN->IDLE when stop=1; next cycle: counter=0, tick=0, grant=0.
REQ-019 In IDLE, counter SHALL hold 0 and tick SHALL be 0.
REQ-020 In RUN, counter SHALL increment by 1 per cycle, wrap to 0 in the cycle after counter==active divisor.
REQ-021 tick SHALL be combinationally high exactly when state==RUN and counter==active divisor.
REQ-022 Latency: start sampled at edge E -> counter=0 after E -> first tick in the cycle starting divisor edges after E; ticks then every divisor+1 cycles.
REQ-023 Divisor 0 SHALL produce tick on every RUN cycle; no divisor value is illegal.
REQ-024 Handshake: transfer occurs when cfg_valid && cfg_ready; cfg_ready = !pending_valid.
REQ-025 Transfer in IDLE SHALL update active divisor at the same edge.
REQ-026 Transfer in RUN SHALL store value in pending register, set pending_valid.
REQ-027 At a terminal-count edge, active divisor SHALL load, in priority: value transferred this cycle, else pending value; pending_valid then clears.
REQ-028 On RUN->IDLE, a pending value SHALL be moved to active and pending_valid cleared.
REQ-029 Arbitration SHALL occur only at tick edges: grant <= next requester with req=1 after last granted index, circular; all-zero if req==0.
REQ-030 Last-granted pointer SHALL update only when a non-zero grant is issued; reset value N_REQ-1 (requester 0 first).
REQ-031 grant SHALL be held for a whole period regardless of req changes in that period.
REQ-032 Counter arithmetic SHALL be WIDTH-bit unsigned; comparison is equality, no overflow path.

Reset
REQ-033 Reset low SHALL force: IDLE, counter=0, active divisor=DIV_RESET, pending_valid=0, pointer=N_REQ-1, grant=0, tick=0, running=0, cfg_ready=1.
REQ-034 Reset asserted mid-period SHALL take effect immediately, no tick or grant pulse emitted.
REQ-035 After reset release, block SHALL stay IDLE until start.

Structure
REQ-036 Shared package/include SHALL hold state encoding (IDLE=0, RUN=1) and default WIDTH/N_REQ/DIV_RESET constants.
REQ-037 Round-robin selection SHALL be a sub-module `rr_arbiter` (req, last pointer -> one-hot grant, next pointer), purely combinational; registers stay in tick_scheduler.

Verification
REQ-038 Reset, cfg divisor=3 in IDLE, start -> tick in cycles 4, 8, 12 after start edge; running=1.
REQ-039 Divisor=0, start -> tick high every RUN cycle; stop -> tick=0 and counter=0 the next cycle.
REQ-040 RUN with divisor=5, cfg 2 mid-period -> cfg_ready=0 until terminal count; period stays 6 then becomes 3.
REQ-041 req=4'b1011, divisor=1 -> grants 0001,0010,1000,0001 on successive ticks; req=0 -> grant=0000.
REQ-042 start and stop both high in IDLE -> stays IDLE; reset pulse mid-RUN with grant=0100 -> all outputs at reset values immediately.
